// File: rtl/enc_sched_pkg.sv
// Shared types and helpers for the encoder MAC scheduler: FSM states,
// fixed-point format constants and packed-operand slice offsets.
package enc_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  // Q-format: FX_FRAC fractional bits, so 1.0 is 1 << FX_FRAC.
  localparam int FX_FRAC = 10;
  localparam int FX_ONE  = 1 << FX_FRAC;

  function automatic int x_off(input int bits, input int i);
    return bits * i;
  endfunction

  function automatic int w_off(input int bits, input int n_out, input int i, input int o);
    return bits * n_out * i + bits * o;
  endfunction

  function automatic int b_off(input int bits, input int o);
    return bits * o;
  endfunction

endpackage

// File: rtl/enc_mac_unit.sv
// Time-shared multiply/accumulate: one fixed-point multiplier, one adder,
// the running accumulator and the bias-or-accumulator select.
module enc_mac_unit
  import enc_sched_pkg::*;
#(
  parameter int BITSIZE = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  input  logic signed [BITSIZE-1:0] bias,
  input  logic                      first,
  input  logic                      en,
  output logic signed [BITSIZE-1:0] acc_next
);

  logic signed [BITSIZE-1:0] acc;

  // Full-precision product, floor-shifted back to the word format and wrapped.
  function automatic logic signed [BITSIZE-1:0] fixed_point_multiply(
    input logic signed [BITSIZE-1:0] fa,
    input logic signed [BITSIZE-1:0] fb
  );
    logic signed [2*BITSIZE-1:0] ae;
    logic signed [2*BITSIZE-1:0] be;
    logic signed [2*BITSIZE-1:0] p;
    ae = {{BITSIZE{fa[BITSIZE-1]}}, fa};
    be = {{BITSIZE{fb[BITSIZE-1]}}, fb};
    p  = ae * be;
    return p[FX_FRAC +: BITSIZE];
  endfunction

  function automatic logic signed [BITSIZE-1:0] fixed_point_add(
    input logic signed [BITSIZE-1:0] fa,
    input logic signed [BITSIZE-1:0] fb
  );
    return fa + fb;
  endfunction

  always_comb acc_next = fixed_point_add(fixed_point_multiply(a, b), first ? bias : acc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/enc_mac_sched.sv
// Round-robin scheduler sharing one MAC between two requesters; computes
// y = W^T x + b one product per cycle and returns y tagged with the requester.
module enc_mac_sched
  import enc_sched_pkg::*;
#(
  parameter int BITSIZE = 20,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req,
  input  logic [BITSIZE*N_IN-1:0]       x0,
  input  logic [BITSIZE*N_IN-1:0]       x1,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w0,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w1,
  input  logic [BITSIZE*N_OUT-1:0]      b0,
  input  logic [BITSIZE*N_OUT-1:0]      b1,
  output logic [1:0]                 ack,
  output logic                       busy,
  output logic [BITSIZE*N_OUT-1:0]   y,
  output logic                       y_valid,
  output logic                       y_id
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t state, state_nx;
  logic grant, rr_last, win, load_grant;
  logic [IW-1:0] i_cnt;
  logic [OW-1:0] o_cnt;
  logic last_i, last_o, mac_en, mac_first;
  logic [BITSIZE*N_IN-1:0]       x_r;
  logic [BITSIZE*N_OUT*N_IN-1:0] w_r;
  logic [BITSIZE*N_OUT-1:0]      b_r, y_reg, y_fin;
  logic signed [BITSIZE-1:0] mac_a, mac_b, mac_bias, acc_next;

  // Single request wins outright; on a tie the requester not granted last wins.
  assign win        = req[1] & (~req[0] | ~rr_last);
  assign load_grant = ((state == IDLE) || (state == DONE)) && (req != 2'b00);

  assign last_i    = (i_cnt == IW'(N_IN - 1));
  assign last_o    = (o_cnt == OW'(N_OUT - 1));
  assign mac_en    = (state == MAC);
  assign mac_first = (i_cnt == '0);
  assign mac_a     = x_r[x_off(BITSIZE, int'(i_cnt)) +: BITSIZE];
  assign mac_b     = w_r[w_off(BITSIZE, N_OUT, int'(i_cnt), int'(o_cnt)) +: BITSIZE];
  assign mac_bias  = b_r[b_off(BITSIZE, int'(o_cnt)) +: BITSIZE];

  assign busy    = (state != IDLE);
  assign y_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    ack      = 2'b00;
    case (state)
      IDLE: if (req != 2'b00) state_nx = LOAD;
      LOAD: begin
        state_nx = MAC;
        ack      = grant ? 2'b10 : 2'b01;
      end
      MAC:  if (last_i && last_o) state_nx = DONE;
      DONE: state_nx = (req != 2'b00) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Row result merged into the current vector as the row completes.
  always_comb begin
    y_fin = y_reg;
    y_fin[b_off(BITSIZE, int'(o_cnt)) +: BITSIZE] = acc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr_last <= 1'b1;
      i_cnt   <= '0;
      o_cnt   <= '0;
      y_reg   <= '0;
      y       <= '0;
      y_id    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_grant) grant <= win;
      if (state == LOAD) begin
        rr_last <= grant;
        i_cnt   <= '0;
        o_cnt   <= '0;
      end else if (mac_en) begin
        if (last_i) begin
          i_cnt <= '0;
          o_cnt <= o_cnt + 1'b1;
          y_reg <= y_fin;
          if (last_o) begin
            y    <= y_fin;
            y_id <= grant;
          end
        end else begin
          i_cnt <= i_cnt + 1'b1;
        end
      end
    end
  end

  // Operands captured at the end of LOAD; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      x_r <= grant ? x1 : x0;
      w_r <= grant ? w1 : w0;
      b_r <= grant ? b1 : b0;
    end
  end

  enc_mac_unit #(.BITSIZE(BITSIZE)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .a        (mac_a),
    .b        (mac_b),
    .bias     (mac_bias),
    .first    (mac_first),
    .en       (mac_en),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_enc_mac_sched.sv
// Directed bench for enc_mac_sched: single jobs, round-robin ties, operand
// isolation, mid-job reset and signed/wrapping arithmetic.
module tb_enc_mac_sched;

  localparam int BS = 20;
  localparam logic [19:0] ONE = 20'h00400;

  logic clk, reset;
  logic [1:0] req;
  logic [119:0] x0, x1;
  logic [239:0] w0, w1;
  logic [39:0] b0, b1;
  logic [1:0] ack;
  logic busy, y_valid, y_id;
  logic [39:0] y;

  int checks = 0;
  int failures = 0;

  enc_mac_sched #(.BITSIZE(BS), .N_IN(6), .N_OUT(2)) dut (
    .clk(clk), .reset(reset), .req(req),
    .x0(x0), .x1(x1), .w0(w0), .w1(w1), .b0(b0), .b1(b1),
    .ack(ack), .busy(busy), .y(y), .y_valid(y_valid), .y_id(y_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] m_mul(input logic [19:0] a, input logic [19:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 10;
    return p[19:0];
  endfunction

  function automatic logic [19:0] m_add(input logic [19:0] a, input logic [19:0] b);
    return a + b;
  endfunction

  function automatic logic [19:0] ref_y(input logic [119:0] xv, input logic [239:0] wv,
                                        input logic [39:0] bv, input int o);
    logic [19:0] acc;
    acc = bv[20*o +: 20];
    for (int i = 0; i < 6; i++) acc = m_add(m_mul(xv[20*i +: 20], wv[40*i + 20*o +: 20]), acc);
    return acc;
  endfunction

  // Issue req, drop it after ack, then check DONE timing and result.
  task automatic run_job(input logic [1:0] r, input logic [1:0] exp_ack, input logic exp_id,
                         input logic [39:0] exp_y, input string tag);
    req = r;
    tick();
    chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
    req = 2'b00;
    repeat (12) tick();
    chk({tag, "_vld_early"}, 64'(y_valid), 64'd0);
    tick();
    chk({tag, "_vld"}, 64'(y_valid), 64'd1);
    chk({tag, "_y"}, 64'(y), 64'(exp_y));
    chk({tag, "_id"}, 64'(y_id), 64'(exp_id));
    tick();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int xo[6] = '{2048, -3072, 1536, -512, 102400, -204800};
    int wc0[6] = '{-1024, -2560, -768, -4096, -8192, -3072};
    int wc1[6] = '{-1, 512, -1280, 3072, -307, 2048};
    int vld_seen;
    logic [39:0] exp_y;

    reset = 1'b1; req = 2'b00;
    x0 = '0; x1 = '0; w0 = '0; w1 = '0; b0 = '0; b1 = '0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_vld", 64'(y_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_id", 64'(y_id), 64'd0);
    reset = 1'b1;
    tick();

    // Single job from requester 0: y0 = 6.0, y1 = 0.
    for (int i = 0; i < 6; i++) begin
      x0[20*i +: 20] = ONE;
      w0[40*i +: 20] = ONE;
      w0[40*i + 20 +: 20] = 20'h0;
    end
    b0 = '0;
    run_job(2'b01, 2'b01, 1'b0, {20'h00000, 20'h01800}, "single");

    // Bias-only job from requester 1.
    for (int i = 0; i < 6; i++) begin
      x1[20*i +: 20] = 20'h0;
      w1[40*i +: 20] = 20'(17 * i + 5);
      w1[40*i + 20 +: 20] = 20'hFFC00;
    end
    b1 = {20'h00456, 20'h00123};
    run_job(2'b10, 2'b10, 1'b1, {20'h00456, 20'h00123}, "bias");

    // Both requesting continuously: grants alternate 0,1,0,1 every 14 cycles.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) tick(); else tick();
      chk($sformatf("tie%0d_ack", k), 64'(ack), (k % 2 == 0) ? 64'd1 : 64'd2);
      repeat (13) tick();
      chk($sformatf("tie%0d_vld", k), 64'(y_valid), 64'd1);
      chk($sformatf("tie%0d_id", k), 64'(y_id), 64'(k % 2));
      chk($sformatf("tie%0d_y", k), 64'(y),
          (k % 2 == 0) ? 64'({20'h00000, 20'h01800}) : 64'({20'h00456, 20'h00123}));
    end
    req = 2'b00;
    tick();
    chk("tie_idle", 64'(busy), 64'd0);

    // Operand change in the first MAC cycle must not affect the job.
    for (int i = 0; i < 6; i++) x0[20*i +: 20] = 20'h00800;
    req = 2'b01;
    tick();
    chk("opchg_ack", 64'(ack), 64'd1);
    req = 2'b00;
    tick();
    for (int i = 0; i < 6; i++) x0[20*i +: 20] = 20'h7FFFF;
    repeat (12) tick();
    chk("opchg_vld", 64'(y_valid), 64'd1);
    chk("opchg_y", 64'(y), 64'({20'h00000, 20'h03000}));
    tick();

    // Reset during MAC cycle 5 discards the job.
    for (int i = 0; i < 6; i++) x0[20*i +: 20] = ONE;
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ack", 64'(ack), 64'd0);
    chk("mrst_y", 64'(y), 64'd0);
    tick();
    reset = 1'b1;
    vld_seen = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (y_valid) vld_seen++;
    end
    chk("mrst_no_vld", 64'(vld_seen), 64'd0);
    run_job(2'b01, 2'b01, 1'b0, {20'h00000, 20'h01800}, "after_rst");

    // Mixed-sign operands with wrapping products against the reference model.
    for (int i = 0; i < 6; i++) begin
      x0[20*i +: 20] = 20'(xo[i]);
      w0[40*i +: 20] = 20'(wc0[i]);
      w0[40*i + 20 +: 20] = 20'(wc1[i]);
    end
    b0 = {20'(1280), 20'(-7168)};
    exp_y = {ref_y(x0, w0, b0, 1), ref_y(x0, w0, b0, 0)};
    run_job(2'b01, 2'b01, 1'b0, exp_y, "signed");

    // Last grant was requester 0, so a tie now goes to requester 1.
    run_job(2'b11, 2'b10, 1'b1, {20'h00456, 20'h00123}, "rr_tie");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_mac_sched.md
# enc_mac_sched

Shared-MAC scheduler for the encoder layers. Two requesters (e.g. two encoder branches) submit a full operand set x, w, b. The block round-robin arbitrates between them and latches the granted operands. It then sequences y = Wᵀx + b over a single time-shared fixed-point multiplier/adder pair, one product per cycle, and returns the result vector tagged with the requester ID.

## Interface
Parameters:
- BITSIZE, 20: fixed-point word width, same format as fixed_point_multiply / fixed_point_add
- N_IN, 6: input vector length
- N_OUT, 2: output vector length

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req  in  2  per-requester level request; bit k = requester k
- x0, x1  in  BITSIZE*N_IN  input vectors; element i at [BITSIZE*i +: BITSIZE]
- w0, w1  in  BITSIZE*N_OUT*N_IN  weights; element (i,o) at [BITSIZE*N_OUT*i + BITSIZE*o +: BITSIZE]
- b0, b1  in  BITSIZE*N_OUT  biases; element o at [BITSIZE*o +: BITSIZE]
- ack  out  2  one-hot, high for exactly the LOAD cycle of the granted requester
- busy  out  1  high in every state except IDLE
- y  out  BITSIZE*N_OUT  result vector; element o at [BITSIZE*o +: BITSIZE]
- y_valid  out  1  single-cycle pulse when y holds a new result
- y_id  out  1  requester index of the current y

## Operation
- States: IDLE, LOAD, MAC, DONE.
- IDLE: if req≠0, go to LOAD with the winner chosen this cycle.
- LOAD: ack[winner]=1; latch x/w/b of the winner into internal registers; clear i, o; go to MAC.
- MAC: every cycle, acc_next = add(mul(x[i], w[i][o]), (i==0) ? b[o] : acc); acc <= acc_next.
  - At i==N_IN-1: y_reg[o] <= acc_next; i <= 0; o <= o+1.
  - Otherwise i <= i+1.
  - Leave MAC after the cycle with i==N_IN-1 and o==N_OUT-1.
- DONE: y_valid=1, y_id=latched winner.
  - Next state is LOAD if req≠0 (arbitration performed in DONE), else IDLE.
- Arbitration: round-robin, with a last-grant pointer updated on each LOAD.
  - If only one req bit is set, that requester wins.
  - If both are set, the requester not granted last wins.
  - Pointer reset value = 1, so requester 0 wins the first tie.
- Requester rules:
  - Hold req and operands stable until ack is seen.
  - req may drop or stay high after ack.
  - A req still high after ack is treated as a new job.
  - Operand changes after LOAD have no effect on the running job.
- Arithmetic:
  - All values are BITSIZE-bit words.
  - Rounding, overflow and sign behaviour are exactly those of fixed_point_multiply / fixed_point_add; no extra widening or saturation.
  - Products accumulate in order i = 0…N_IN-1.
- y, y_id hold their last values until the next DONE; they are not cleared on IDLE.
- Reset (asynchronous, any state):
  - State → IDLE; counters, acc, y_reg → 0; y_id → 0; rr pointer → 1.
  - ack, busy, y_valid → 0.
  - An in-flight job is discarded with no y_valid; the requester must re-request.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from req to ack within the same cycle.
- req sampled high in IDLE at edge t → ack high in cycle t+1 (LOAD).
- MAC occupies cycles t+2 … t+1+N_IN·N_OUT.
- y_valid is high in cycle t+2+N_IN·N_OUT; this is t+14 at the defaults.
- Back-to-back jobs: DONE→LOAD directly, giving a period of N_IN·N_OUT+2 cycles.
- Row o result appears internally in y_reg after row completion; y_valid still marks whole-vector completion only.

## Structure
- Package enc_sched_pkg holds:
  - state enum (IDLE/LOAD/MAC/DONE);
  - FX_ONE constant, the 1.0 encoding in the fixed_point_multiply format;
  - index helper functions for the x/w/b slice offsets.
- Sub-module enc_mac_unit: one fixed_point_multiply, one fixed_point_add, the acc register and bias-select mux.
  - Inputs: a, b, bias, first, en.
  - Output: acc_next.
- Top level holds the FSM, arbiter, operand registers, counters and y_reg.

## Test plan
- Single job: req=01; x0 all FX_ONE; w0[i][0]=FX_ONE, w0[i][1]=0; b0=0. Expect:
  - ack=01 at t+1;
  - y_valid at t+14, with y0=6·FX_ONE, y1=0, y_id=0;
  - busy low at t+15.
- Bias only: x1=0, w1 arbitrary, b1={0x00123,0x00456}, req=10. Expect y={0x00123,0x00456} and y_id=1.
- Simultaneous: req=11 held continuously. Expect:
  - grants 0,1,0,1 with a period of 14 cycles;
  - y_valid every 14 cycles;
  - y_id alternates.
- Operand change after ack: modify x0 in the cycle after ack. Expect the result to match the pre-ack operands.
- Mid-job reset: assert reset low during MAC cycle 5 for 1 cycle. Expect:
  - immediate busy=0, ack=0, y=0;
  - no y_valid;
  - a subsequent req=01 completes normally 14 cycles later.
- Directed overflow/sign: negative weights, mixed-sign x. Expect y to equal the reference model using the same fixed_point_multiply/add functions, bit-exact.
